// File: rtl/approx_err_monitor.sv
// Error-metric collector for approximate adders: accumulates count, error count,
// signed/absolute/squared error sums and max |error| over a programmed run of N pairs.
module approx_err_monitor #(
  parameter int SUM_W = 9,
  parameter int CNT_W = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_samples,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SUM_W-1:0]         approx_sum,
  input  logic [SUM_W-1:0]         exact_sum,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [SUM_W+CNT_W:0]     err_sum,
  output logic [SUM_W+CNT_W-1:0]   abs_err_sum,
  output logic [2*SUM_W+CNT_W-1:0] sq_err_sum,
  output logic [SUM_W-1:0]         max_abs_err
);

  localparam int ES_W  = SUM_W + CNT_W + 1;
  localparam int AS_W  = SUM_W + CNT_W;
  localparam int SQ_W  = 2*SUM_W + CNT_W;
  localparam int SQT_W = 2*SUM_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        n_lat_reg;
  logic [CNT_W-1:0]        acc_cnt_reg;
  logic                    s1_valid_reg;
  logic signed [SUM_W:0]   s1_err_reg;
  logic [SUM_W-1:0]        s1_abs_reg;

  logic                    accept;
  logic                    start_ok;
  logic signed [SUM_W:0]   diff;
  logic [SUM_W-1:0]        diff_abs;
  logic [SQT_W-1:0]        sq_term;

  assign in_ready = (state_reg == RUN) && (acc_cnt_reg < n_lat_reg);
  assign accept   = in_valid & in_ready;
  assign start_ok = (state_reg == IDLE) & start;

  assign diff     = $signed({1'b0, approx_sum}) - $signed({1'b0, exact_sum});
  assign diff_abs = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                              : (exact_sum - approx_sum);
  assign sq_term  = SQT_W'(s1_abs_reg) * SQT_W'(s1_abs_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      n_lat_reg   <= '0;
      acc_cnt_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_lat_reg   <= num_samples;
            acc_cnt_reg <= '0;
            busy        <= 1'b1;
            state_reg   <= (num_samples == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
            if (acc_cnt_reg == n_lat_reg - CNT_W'(1))
              state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Wait for the last stage-1 sample to land in the accumulators.
          if (!s1_valid_reg) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= '0;
      s1_abs_reg   <= '0;
      sample_cnt   <= '0;
      err_cnt      <= '0;
      err_sum      <= '0;
      abs_err_sum  <= '0;
      sq_err_sum   <= '0;
      max_abs_err  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_err_reg <= diff;
        s1_abs_reg <= diff_abs;
      end
      if (start_ok) begin
        sample_cnt  <= '0;
        err_cnt     <= '0;
        err_sum     <= '0;
        abs_err_sum <= '0;
        sq_err_sum  <= '0;
        max_abs_err <= '0;
      end else if (s1_valid_reg) begin
        sample_cnt  <= sample_cnt + CNT_W'(1);
        err_cnt     <= err_cnt + CNT_W'(s1_err_reg != '0);
        err_sum     <= err_sum + ES_W'(s1_err_reg);
        abs_err_sum <= abs_err_sum + AS_W'(s1_abs_reg);
        sq_err_sum  <= sq_err_sum + SQ_W'(sq_term);
        if (s1_abs_reg > max_abs_err)
          max_abs_err <= s1_abs_reg;
      end
    end
  end

endmodule
